// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: plays 24 solver moves back as two motion
// commands each (vertical leg, then horizontal leg with fanfare).
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        busy,
    output logic        tour_done,
    output logic        move_err
);

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [4:0] LAST_MOVE = 5'd23;

    state_t      state;
    state_t      next_state;
    logic [4:0]  next_indx;
    logic        done_set;
    logic        err_set;
    logic        move_ok;
    logic        north;
    logic        east;
    logic [3:0]  v_sq;
    logic [3:0]  h_sq;

    // Direction and leg lengths for each one-hot knight move.
    always_comb begin
        north = 1'b0;
        east  = 1'b0;
        v_sq  = 4'd0;
        h_sq  = 4'd0;
        case (move)
            8'h01: begin north = 1'b1; v_sq = 4'd2; east = 1'b1; h_sq = 4'd1; end
            8'h02: begin north = 1'b1; v_sq = 4'd2; east = 1'b0; h_sq = 4'd1; end
            8'h04: begin north = 1'b1; v_sq = 4'd1; east = 1'b0; h_sq = 4'd2; end
            8'h08: begin north = 1'b0; v_sq = 4'd1; east = 1'b0; h_sq = 4'd2; end
            8'h10: begin north = 1'b0; v_sq = 4'd2; east = 1'b0; h_sq = 4'd1; end
            8'h20: begin north = 1'b0; v_sq = 4'd2; east = 1'b1; h_sq = 4'd1; end
            8'h40: begin north = 1'b0; v_sq = 4'd1; east = 1'b1; h_sq = 4'd2; end
            8'h80: begin north = 1'b1; v_sq = 4'd1; east = 1'b1; h_sq = 4'd2; end
            default: ;
        endcase
    end

    assign move_ok = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

    always_comb begin
        next_state = state;
        next_indx  = mv_indx;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start_tour) begin
                    next_state = VERT;
                    next_indx  = 5'd0;
                end
            end
            VERT: begin
                // A bad move aborts the tour even if the consumer is taking cmd.
                if (!move_ok) begin
                    next_state = IDLE;
                    next_indx  = 5'd0;
                    err_set    = 1'b1;
                end else if (clr_cmd_rdy) begin
                    next_state = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) next_state = HORZ;
            end
            HORZ: begin
                if (clr_cmd_rdy) next_state = WAIT_H;
            end
            WAIT_H: begin
                if (send_resp) begin
                    if (mv_indx == LAST_MOVE) begin
                        next_state = IDLE;
                        next_indx  = 5'd0;
                        done_set   = 1'b1;
                    end else begin
                        next_state = VERT;
                        next_indx  = mv_indx + 5'd1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_indx  = 5'd0;
            end
        endcase
    end

    // cmd stays on the current leg through its wait state.
    always_comb begin
        cmd = 16'h0000;
        case (state)
            VERT, WAIT_V: cmd = {4'h2, (north ? 8'h00 : 8'h7F), v_sq};
            HORZ, WAIT_H: cmd = {4'h3, (east ? 8'hBF : 8'h3F), h_sq};
            default:      cmd = 16'h0000;
        endcase
    end

    assign cmd_rdy = (state == VERT) || (state == HORZ);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mv_indx   <= 5'd0;
            tour_done <= 1'b0;
            move_err  <= 1'b0;
        end else begin
            state     <= next_state;
            mv_indx   <= next_indx;
            tour_done <= done_set;
            move_err  <= err_set;
        end
    end

endmodule
